// File: rtl/srio_rx_type9_filter_pkg.sv
// Shared SRIO receive definitions: FTYPE field layout, FSM states and the
// header routing decision used by the type-9 filter.
package srio_pkg;

  localparam logic [3:0] FTYPE_DS = 4'd9;
  localparam int         FTYPE_HI = 55;
  localparam int         FTYPE_LO = 52;

  typedef enum logic [1:0] {
    IDLE,
    FWD_T9,
    FWD_OTH,
    DROP
  } rx_state_e;

  typedef enum logic [1:0] {
    RT_DROP,
    RT_T9,
    RT_OTH
  } route_e;

  // Destination of a packet, decided once from its header beat.
  function automatic route_e hdr_route(input logic en, input logic [3:0] ftype,
                                       input logic oth_en);
    if (!en) return RT_DROP;
    if (ftype == FTYPE_DS) return RT_T9;
    return oth_en ? RT_OTH : RT_DROP;
  endfunction

endpackage

// File: rtl/srio_rx_type9_filter_reg_slice.sv
// One-entry AXI-Stream output register (data + last). The owner loads it
// only when free; contents hold until the consumer takes them.
module srio_axis_reg_slice #(
  parameter int DW = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [DW-1:0] in_data,
  input  logic          in_last,
  input  logic          out_ready,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  output logic          out_last,
  output logic          free
);

  logic          valid_q, valid_d;
  logic [DW-1:0] data_q, data_d;
  logic          last_q, last_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    last_d  = last_q;
    if (load) begin
      valid_d = 1'b1;
      data_d  = in_data;
      last_d  = in_last;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      last_q  <= last_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_last  = last_q;
  assign free      = !valid_q || out_ready;

endmodule

// File: rtl/srio_rx_type9_filter.sv
// SRIO receive router: steers type-9 packets to the unpacker port, other
// FTYPEs to a secondary port (or drops them), truncates oversize packets.
module srio_rx_type9_filter
  import srio_pkg::*;
#(
  parameter int MAX_BEATS = 33,
  parameter int CNT_W     = 16,
  parameter int OTHER_EN  = 1
) (
  input  logic             AXIS_ACLK,
  input  logic             AXIS_ARESETN,
  input  logic             enable,
  input  logic [63:0]      S_AXIS_TDATA,
  input  logic             S_AXIS_TVALID,
  input  logic             S_AXIS_TLAST,
  output logic             S_AXIS_TREADY,
  output logic [63:0]      M_AXIS_T9_TDATA,
  output logic             M_AXIS_T9_TVALID,
  output logic             M_AXIS_T9_TLAST,
  input  logic             M_AXIS_T9_TREADY,
  output logic [63:0]      M_AXIS_OTH_TDATA,
  output logic             M_AXIS_OTH_TVALID,
  output logic             M_AXIS_OTH_TLAST,
  input  logic             M_AXIS_OTH_TREADY,
  output logic [CNT_W-1:0] t9_count,
  output logic [CNT_W-1:0] oth_count,
  output logic [CNT_W-1:0] drop_count,
  output logic [CNT_W-1:0] err_count
);

  localparam int BW = $clog2(MAX_BEATS + 1);

  rx_state_e        state_q, state_d;
  logic [BW-1:0]    beat_cnt_q, beat_cnt_d, beat_num;
  logic [CNT_W-1:0] t9_cnt_q, t9_cnt_d, oth_cnt_q, oth_cnt_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d, err_cnt_q, err_cnt_d;
  route_e           route;
  logic             t9_free, oth_free, t9_load, oth_load, fwd_last;
  logic             rdy, acc, over, is_idle, to_t9, to_oth;

  assign route   = hdr_route(enable, S_AXIS_TDATA[FTYPE_HI:FTYPE_LO], OTHER_EN != 0);
  assign is_idle = (state_q == IDLE);
  // Beat number of the beat currently offered; the header is beat 1.
  assign beat_num = is_idle ? BW'(1) : beat_cnt_q + BW'(1);
  assign over     = (beat_num == BW'(MAX_BEATS)) && !S_AXIS_TLAST;
  assign to_t9    = (state_q == FWD_T9)  || (is_idle && route == RT_T9);
  assign to_oth   = (state_q == FWD_OTH) || (is_idle && route == RT_OTH);

  always_comb begin
    rdy = 1'b1;
    case (state_q)
      IDLE: begin
        case (route)
          RT_T9:   rdy = t9_free;
          RT_OTH:  rdy = oth_free;
          default: rdy = 1'b1;
        endcase
      end
      FWD_T9:  rdy = t9_free;
      FWD_OTH: rdy = oth_free;
      default: rdy = 1'b1;
    endcase
  end

  assign S_AXIS_TREADY = AXIS_ARESETN && rdy;
  assign acc           = S_AXIS_TVALID && S_AXIS_TREADY;

  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    t9_cnt_d   = t9_cnt_q;
    oth_cnt_d  = oth_cnt_q;
    drop_cnt_d = drop_cnt_q;
    err_cnt_d  = err_cnt_q;
    t9_load    = 1'b0;
    oth_load   = 1'b0;
    fwd_last   = S_AXIS_TLAST || over;
    if (acc) begin
      if (to_t9 || to_oth) begin
        t9_load  = to_t9;
        oth_load = to_oth;
        if (is_idle && to_t9)  t9_cnt_d  = t9_cnt_q + CNT_W'(1);
        if (is_idle && to_oth) oth_cnt_d = oth_cnt_q + CNT_W'(1);
        if (S_AXIS_TLAST) begin
          state_d    = IDLE;
          beat_cnt_d = '0;
        end else if (over) begin
          // Truncated: the output saw a forced TLAST, swallow the rest.
          err_cnt_d  = err_cnt_q + CNT_W'(1);
          state_d    = DROP;
          beat_cnt_d = '0;
        end else begin
          state_d    = to_t9 ? FWD_T9 : FWD_OTH;
          beat_cnt_d = beat_num;
        end
      end else begin
        if (is_idle) drop_cnt_d = drop_cnt_q + CNT_W'(1);
        state_d    = S_AXIS_TLAST ? IDLE : DROP;
        beat_cnt_d = '0;
      end
    end
  end

  always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
    if (!AXIS_ARESETN) begin
      state_q    <= IDLE;
      beat_cnt_q <= '0;
      t9_cnt_q   <= '0;
      oth_cnt_q  <= '0;
      drop_cnt_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      t9_cnt_q   <= t9_cnt_d;
      oth_cnt_q  <= oth_cnt_d;
      drop_cnt_q <= drop_cnt_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign t9_count   = t9_cnt_q;
  assign oth_count  = oth_cnt_q;
  assign drop_count = drop_cnt_q;
  assign err_count  = err_cnt_q;

  srio_axis_reg_slice #(.DW(64)) u_t9 (
    .clk       (AXIS_ACLK),
    .rst_n     (AXIS_ARESETN),
    .load      (t9_load),
    .in_data   (S_AXIS_TDATA),
    .in_last   (fwd_last),
    .out_ready (M_AXIS_T9_TREADY),
    .out_valid (M_AXIS_T9_TVALID),
    .out_data  (M_AXIS_T9_TDATA),
    .out_last  (M_AXIS_T9_TLAST),
    .free      (t9_free)
  );

  generate
    if (OTHER_EN != 0) begin : g_oth
      srio_axis_reg_slice #(.DW(64)) u_oth (
        .clk       (AXIS_ACLK),
        .rst_n     (AXIS_ARESETN),
        .load      (oth_load),
        .in_data   (S_AXIS_TDATA),
        .in_last   (fwd_last),
        .out_ready (M_AXIS_OTH_TREADY),
        .out_valid (M_AXIS_OTH_TVALID),
        .out_data  (M_AXIS_OTH_TDATA),
        .out_last  (M_AXIS_OTH_TLAST),
        .free      (oth_free)
      );
    end else begin : g_no_oth
      // Routing never selects OTH here, so the free flag is never consulted.
      assign M_AXIS_OTH_TVALID = 1'b0;
      assign M_AXIS_OTH_TDATA  = '0;
      assign M_AXIS_OTH_TLAST  = 1'b0;
      assign oth_free          = 1'b0;
    end
  endgenerate

endmodule

// File: doc/srio_rx_type9_filter.md
# srio_rx_type9_filter

Receive-side packet router between the SRIO endpoint's 64-bit AXI-Stream user port and `srio_type9_unpack`. It inspects the header beat of each incoming packet and steers the whole packet by FTYPE:

- Type 9 (data streaming) goes to the type-9 output that feeds the unpacker.
- All other FTYPEs go to a secondary output, or are discarded.

It also guards against runaway packets by enforcing a maximum beat count, and keeps wrap-around statistics counters for the register interface.

## Interface
Parameters:
- `MAX_BEATS`, default 33: maximum beats per packet, including the header beat (32 payload beats of 8 bytes = 256-byte SRIO maximum, plus 1 header).
- `CNT_W`, default 16: width of each statistics counter.
- `OTHER_EN`, default 1: 1 forwards non-type-9 packets to `M_AXIS_OTH`; 0 drops them (OTH outputs tied off, `M_AXIS_OTH_TVALID`=0).

Ports:
- `AXIS_ACLK` in 1: sole clock.
- `AXIS_ARESETN` in 1: reset, asynchronous, active-low.
- `enable` in 1: 0 drops all new packets. Sampled only on header beats.
- `S_AXIS_TDATA` in 64: input data; the header beat carries FTYPE in [55:52].
- `S_AXIS_TVALID` in 1, `S_AXIS_TLAST` in 1, `S_AXIS_TREADY` out 1: input handshake.
- `M_AXIS_T9_TDATA` out 64, `M_AXIS_T9_TVALID` out 1, `M_AXIS_T9_TLAST` out 1, `M_AXIS_T9_TREADY` in 1: type-9 output, to `srio_type9_unpack`.
- `M_AXIS_OTH_TDATA` out 64, `M_AXIS_OTH_TVALID` out 1, `M_AXIS_OTH_TLAST` out 1, `M_AXIS_OTH_TREADY` in 1: non-type-9 output.
- `t9_count` out CNT_W: type-9 packets accepted.
- `oth_count` out CNT_W: other packets forwarded.
- `drop_count` out CNT_W: packets dropped (disabled, or other with OTHER_EN=0).
- `err_count` out CNT_W: oversize packets truncated.

## Operation
- FSM states: IDLE, FWD_T9, FWD_OTH, DROP.
- IDLE decode, applied to the header beat (`S_AXIS_TVALID`=1 in IDLE):
  - `enable`=0 → packet dropped.
  - FTYPE=9 → routed to T9.
  - Other FTYPE → routed to OTH if OTHER_EN=1, else dropped.
- The header beat is forwarded unchanged; the unpacker needs it.
- Counters increment once per packet, on the accepted header beat.
- Single-beat packet (header beat with TLAST): routed and counted, FSM stays in IDLE.
- FWD_T9 / FWD_OTH: every accepted beat is copied to the selected output. Return to IDLE on the accepted beat with TLAST.
- DROP: `S_AXIS_TREADY`=1, beats are discarded, return to IDLE on TLAST.
- Beat counter: counts accepted beats of the current packet, header = 1.
  - If beat number MAX_BEATS is forwarded without TLAST, that output beat gets TLAST forced to 1 and `err_count` increments.
  - The FSM then enters DROP and discards the remainder up to the real TLAST.
- `enable` changing mid-packet has no effect until the next header beat.
- Counters wrap from 2^CNT_W−1 to 0.

## Timing
- Each output has a one-entry output register. Latency is 1 cycle from input acceptance to output TVALID.
- Slot free condition: `!TVALID || TREADY` of that output. This gives full throughput (one beat per cycle) when downstream holds TREADY=1.
- `S_AXIS_TREADY`:
  - FWD_T9: T9 slot free.
  - FWD_OTH: OTH slot free.
  - DROP: 1.
  - IDLE: the free condition of the slot the current TDATA[55:52]/`enable` selects. A drop decision gives 1.
  - This is a combinational dependency on TDATA, legal because AXIS holds TDATA stable while TVALID=1.
- Output TVALID/TDATA/TLAST hold stable until TREADY=1. TVALID never depends on TREADY.
- Reset (asynchronous, any time including mid-packet):
  - State → IDLE; all TVALID, TLAST, TDATA → 0; beat counter and all four counters → 0; `S_AXIS_TREADY`=0 while `AXIS_ARESETN`=0.
  - After release, the next beat seen is treated as a header.
- Both outputs may hold valid data simultaneously, e.g. an OTH beat still stalled while a T9 packet starts. The two do not interact.

## Structure
- Shared package `srio_pkg`:
  - `FTYPE_DS`=4'd9.
  - FTYPE field position constants `FTYPE_HI`=55, `FTYPE_LO`=52.
  - FSM state enum.
- Natural sub-module: `srio_axis_reg_slice`, a one-entry 64+1-bit register slice, instantiated twice (T9 and OTH).
- Counters and the FSM stay in the top module.

## Test plan
- Type-9 packet of 4 beats (header TDATA[55:52]=9), TREADY=1 → 4 beats on T9 in consecutive cycles, 1 cycle delayed, TLAST on 4th; `t9_count`=1; OTH idle.
- FTYPE=5 packet of 3 beats with OTHER_EN=1 → 3 beats on OTH, `oth_count`=1. Rebuild with OTHER_EN=0 → `S_AXIS_TREADY`=1 throughout, nothing output, `drop_count`=1.
- Type-9 packet of 40 beats, MAX_BEATS=33 → 33 beats out with TLAST on beat 33; beats 34–40 consumed silently; `err_count`=1; next packet routes normally.
- Back-to-back single-beat packets alternating FTYPE 9/5 with random TREADY throttling on both outputs → no loss, no duplication, order preserved per output, data stable under stall.
- `enable` deasserted during beat 2 of a 5-beat type-9 packet → all 5 beats forwarded; next type-9 packet dropped and `drop_count`+1.
- `AXIS_ARESETN` pulsed low at beat 3 of 6 with T9 stalled → outputs and counters are 0 immediately. After release, a fresh 2-beat type-9 packet is forwarded and `t9_count`=1.
